melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Sequences short stored melodies into the 4-bit tone codes consumed by the downstream square-wave tone generator. The game-control logic pulses `start` with a melody select when a round ends, and this block steps through an internal note ROM, holding each tone for a programmed duration with a short silent gap between notes. It then reports completion. Its `tone` output connects directly to the tone generator's `tone` input; code 0 means silence, and codes 1–15 map to C3..C5 in C major.

## Interface
- `UNIT_CYCLES`, default 6_250_000: clock cycles per duration unit (125 ms at 50 MHz); must be greater than `GAP_CYCLES`.
- `GAP_CYCLES`, default 500_000: silent cycles inserted at the end of every note; must be at least 1.
- `clk`  in  1: system clock, 50 MHz, all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to play; sampled only in IDLE.
- `sel`  in  1: melody select, latched with `start`; 0 = win, 1 = lose.
- `stop`  in  1: synchronous abort; forces silence and return to IDLE.
- `tone`  out  4: registered tone code to the tone generator.
- `busy`  out  1: registered; high from the accepted `start` until return to IDLE.
- `done`  out  1: registered one-cycle pulse when a melody finishes normally.

## Operation
- ROM: 2 melodies × 16 entries, each entry {tone[3:0], len[3:0]}. `len` = 0 is the end marker.
  - Melody 0: (8,2) (10,2) (12,2) (15,6) (0,0)…
  - Melody 1: (5,2) (4,2) (3,2) (1,6) (0,0)…
  - All unused entries are end markers.
- Address is 4 bits. After entry 15 is played, the melody ends as if entry 16 were an end marker; the address never wraps.
- States: IDLE, FETCH, PLAY, GAP, DONE.
  - IDLE: tone=0, busy=0. If `start` is high, latch `sel`, set addr=0 → FETCH.
  - FETCH: tone=0. If entry `len` = 0 → DONE. Otherwise tone ← entry tone, load counter with len·UNIT_CYCLES − GAP_CYCLES − 1 → PLAY.
  - PLAY: tone held. When the counter reaches 0, tone ← 0, load counter with GAP_CYCLES − 1 → GAP.
  - GAP: tone=0. When the counter reaches 0: if addr = 15 → DONE, else addr+1 → FETCH.
  - DONE: done=1 for exactly one cycle → IDLE.
- An entry with tone = 0 and len ≠ 0 is a rest: it is timed normally with silent output.
- Counter is a down-counter with width $clog2(15·UNIT_CYCLES). Products are computed at full width; there is no truncation.
- `stop` has priority over every state transition. The next edge gives tone=0, busy=0, done=0, state IDLE, and no done pulse.
- `start` while busy is ignored. `start` and `stop` together in IDLE: `stop` wins and the block stays IDLE.

## Timing
- Reset values: tone=0, busy=0, done=0, state IDLE, addr=0, counter=0, latched sel=0.
- `start` sampled at edge E: busy=1 and state FETCH after E. The first tone is visible after E+1.
- Each note: tone held for len·UNIT_CYCLES − GAP_CYCLES cycles, then 0 for GAP_CYCLES + 1 cycles (GAP plus the next FETCH).
- Total per note, FETCH to FETCH: len·UNIT_CYCLES + 1 cycles.
- End-marker FETCH at edge F: done=1 after F+1; done=0, busy=0 after F+2.
- A new `start` is accepted in the cycle immediately after busy falls.
- Asynchronous reset mid-melody clears all outputs immediately, independent of `clk`.

## Test plan
- Parameters UNIT_CYCLES=10, GAP_CYCLES=2, `start` with sel=0 at edge 0:
  - tone=8 over edges 1–18, 0 over 19–21, 10 over 22–39, 0 over 40–42, 12 over 43–60, 0 over 61–63, 15 over 64–121, 0 afterwards;
  - done=1 only after edge 125; busy falls after edge 126.
- Same with sel=1 → tone sequence 5, 4, 3, 1 with identical timing. `sel` toggled mid-melody has no effect.
- `stop` asserted during the third note (edge 50) → tone=0 and busy=0 after edge 50, done never pulses. A new `start` at edge 52 replays from entry 0.
- `start` pulsed at edges 5 and 80 during playback → ignored; total timing unchanged, single done pulse.
- `rst_n` low at edge 30 mid-note → tone, busy, and done go to 0 immediately. After release, the block sits in IDLE until `start`.
- Back-to-back: `start` in the first cycle with busy=0 after done → second melody begins, first tone visible 2 cycles later.

Source files
------------

// File: rtl/melody_sequencer.sv
// Plays one of two stored melodies as 4-bit tone codes for the square-wave tone generator.
// Each note is held for len*UNIT_CYCLES - GAP_CYCLES cycles, then silenced for the gap.
module melody_sequencer #(
  parameter int unsigned UNIT_CYCLES = 6_250_000,
  parameter int unsigned GAP_CYCLES  = 500_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_sel,
  input  logic       i_stop,
  output logic [3:0] o_tone,
  output logic       o_busy,
  output logic       o_done
);

  // 15*UNIT_CYCLES is never a power of two, so every count value below it fits in CntW bits.
  localparam int unsigned CntW = $clog2(15 * UNIT_CYCLES);
  localparam logic [CntW-1:0] UnitCnt = CntW'(UNIT_CYCLES);
  localparam logic [CntW-1:0] GapCnt  = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPlay,
    StGap,
    StDone
  } state_e;

  state_e          r_state;
  logic [3:0]      r_addr;
  logic            r_sel;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      r_tone;
  logic            r_busy;
  logic            r_done;

  logic [7:0]      w_entry;
  logic [3:0]      w_tone;
  logic [3:0]      w_len;
  logic [CntW-1:0] w_play_load;

  // Note ROM: {tone, len}; len == 0 marks the end of a melody.
  always_comb begin
    w_entry = 8'h00;
    case ({r_sel, r_addr})
      5'h00:   w_entry = {4'd8,  4'd2};
      5'h01:   w_entry = {4'd10, 4'd2};
      5'h02:   w_entry = {4'd12, 4'd2};
      5'h03:   w_entry = {4'd15, 4'd6};
      5'h10:   w_entry = {4'd5,  4'd2};
      5'h11:   w_entry = {4'd4,  4'd2};
      5'h12:   w_entry = {4'd3,  4'd2};
      5'h13:   w_entry = {4'd1,  4'd6};
      default: w_entry = 8'h00;
    endcase
  end

  assign w_tone      = w_entry[7:4];
  assign w_len       = w_entry[3:0];
  assign w_play_load = CntW'(w_len) * UnitCnt - GapCnt - OneCnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_addr  <= 4'd0;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
      r_tone  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_stop) begin
      r_state <= StIdle;
      r_tone  <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_tone <= 4'd0;
          if (i_start) begin
            r_sel   <= i_sel;
            r_addr  <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= StFetch;
          end
        end
        StFetch: begin
          if (w_len == 4'd0) begin
            r_tone  <= 4'd0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_tone  <= w_tone;
            r_cnt   <= w_play_load;
            r_state <= StPlay;
          end
        end
        StPlay: begin
          if (r_cnt == '0) begin
            r_tone  <= 4'd0;
            r_cnt   <= GapCnt - OneCnt;
            r_state <= StGap;
          end else begin
            r_cnt <= r_cnt - OneCnt;
          end
        end
        StGap: begin
          if (r_cnt == '0) begin
            // The address never wraps: running past entry 15 ends the melody.
            if (r_addr == 4'hF) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_addr  <= r_addr + 4'd1;
              r_state <= StFetch;
            end
          end else begin
            r_cnt <= r_cnt - OneCnt;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_tone  <= 4'd0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_tone = r_tone;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with UNIT_CYCLES=10, GAP_CYCLES=2.
// Edge numbers are counted from the edge that samples start (edge 0); outputs sampled on negedge.
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] tone;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  melody_sequencer #(
    .UNIT_CYCLES(10),
    .GAP_CYCLES (2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_sel  (sel),
    .i_stop (stop),
    .o_tone (tone),
    .o_busy (busy),
    .o_done (done)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int e, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %0d, expected %0d", tag, e, obs, exp);
    end
  endtask

  // Hand-derived schedule: notes of len 2,2,2,6 at unit 10, gap 2.
  function automatic logic [3:0] exp_tone(input bit m, input int e);
    logic [3:0] t0 [4];
    logic [3:0] t1 [4];
    int idx;
    t0 = '{4'd8, 4'd10, 4'd12, 4'd15};
    t1 = '{4'd5, 4'd4, 4'd3, 4'd1};
    idx = -1;
    if (e >= 1 && e <= 18) idx = 0;
    else if (e >= 22 && e <= 39) idx = 1;
    else if (e >= 43 && e <= 60) idx = 2;
    else if (e >= 64 && e <= 121) idx = 3;
    if (idx < 0) return 4'd0;
    return m ? t1[idx] : t0[idx];
  endfunction

  task automatic chk_all(input string tag, input int e, input bit m, input int busy_until,
                         input int done_at);
    chk({tag, ":tone"}, e, 32'(tone), 32'(exp_tone(m, e)));
    chk({tag, ":busy"}, e, 32'(busy), 32'(e <= busy_until));
    chk({tag, ":done"}, e, 32'(done), 32'(e == done_at));
  endtask

  // Call at a negedge with start/sel already set; leaves the bench just after edge `upto`.
  task automatic play(input string tag, input bit m, input int upto, input bit noise);
    next();
    start = 1'b0;
    chk_all(tag, 0, m, 125, 125);
    for (int e = 1; e <= upto; e++) begin
      if (noise) begin
        start = (e == 5 || e == 80);
        sel   = ~sel;
      end
      next();
      chk_all(tag, e, m, 125, 125);
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset:tone", -1, 32'(tone), 32'd0);
    chk("reset:busy", -1, 32'(busy), 32'd0);
    chk("reset:done", -1, 32'(done), 32'd0);
    next();
    rst_n = 1'b1;
    next();
    next();
    chk("idle:busy", -1, 32'(busy), 32'd0);

    // Win melody, full run through the done pulse and busy fall
    start = 1'b1;
    sel   = 1'b0;
    play("win", 1'b0, 126, 1'b0);

    // Back-to-back: start in the first busy=0 cycle, lose melody, sel toggled throughout
    start = 1'b1;
    sel   = 1'b1;
    next();
    start = 1'b0;
    chk_all("b2b", 0, 1'b1, 125, 125);
    for (int e = 1; e <= 128; e++) begin
      sel = ~sel;
      next();
      chk_all("b2b", e, 1'b1, 125, 125);
    end

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    next();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop:busy", 0, 32'(busy), 32'd0);
    next();
    chk("startstop:tone", 1, 32'(tone), 32'd0);

    // Stop during the third note at edge 50
    start = 1'b1;
    sel   = 1'b0;
    play("stop", 1'b0, 49, 1'b0);
    stop = 1'b1;
    next();
    stop = 1'b0;
    chk("stop:tone", 50, 32'(tone), 32'd0);
    chk("stop:busy", 50, 32'(busy), 32'd0);
    chk("stop:done", 50, 32'(done), 32'd0);
    next();
    chk("stop:idle_tone", 51, 32'(tone), 32'd0);
    chk("stop:idle_done", 51, 32'(done), 32'd0);

    // Restart after stop replays from entry 0; start pulses at 5 and 80 ignored
    start = 1'b1;
    sel   = 1'b0;
    play("noise", 1'b0, 130, 1'b1);

    // Async reset mid-note: outputs clear without a clock edge
    start = 1'b1;
    sel   = 1'b1;
    play("rst", 1'b1, 29, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst:tone", 30, 32'(tone), 32'd0);
    chk("arst:busy", 30, 32'(busy), 32'd0);
    chk("arst:done", 30, 32'(done), 32'd0);
    next();
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next();
      chk("arst:idle_busy", i, 32'(busy), 32'd0);
      chk("arst:idle_tone", i, 32'(tone), 32'd0);
    end

    // After reset, a fresh start plays the win melody (latched sel cleared to 0)
    start = 1'b1;
    sel   = 1'b0;
    play("post", 1'b0, 20, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
